// File: rtl/tdm_demux.sv
// tdm_demux: word-serial TDM demultiplexer with frame hunt/lock.
// Ports: clk, rst_n, din/din_valid/frame_sync in; dout/dout_valid/locked/frame_err out.
module tdm_demux #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          din,
  input  logic                      din_valid,
  input  logic                      frame_sync,
  output logic [CHANNELS*WIDTH-1:0] dout,
  output logic                      dout_valid,
  output logic                      locked,
  output logic                      frame_err
);

  localparam int SW = $clog2(CHANNELS);
  localparam logic [SW-1:0] LAST = SW'(CHANNELS - 1);

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t state;
  state_t state_nx;

  logic [SW-1:0] slot;
  logic [SW-1:0] slot_nx;

  logic [WIDTH-1:0] shadow [CHANNELS-1];

  logic at_first;
  logic at_last;
  logic start;
  logic store;
  logic done;
  logic err;

  logic [CHANNELS*WIDTH-1:0] frame;

  assign at_first = (slot == '0);
  assign at_last  = (slot == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
    end else begin
      state <= state_nx;
    end
  end

  // A missing sync at slot 0 is the only way out of LOCK;
  // an early sync re-locks in place.
  always_comb begin
    state_nx = state;
    unique case (state)
      HUNT: begin
        if (din_valid && frame_sync) begin
          state_nx = LOCK;
        end
      end
      LOCK: begin
        if (din_valid && !frame_sync && at_first) begin
          state_nx = HUNT;
        end
      end
    endcase
  end

  // Per-word event decode. A sync at the last slot is an
  // early sync, so done requires frame_sync low.
  always_comb begin
    start = 1'b0;
    store = 1'b0;
    done  = 1'b0;
    err   = 1'b0;
    if (din_valid) begin
      unique case (state)
        HUNT: begin
          start = frame_sync;
        end
        LOCK: begin
          start = frame_sync;
          err   = frame_sync ? !at_first : at_first;
          store = !frame_sync && !at_first && !at_last;
          done  = !frame_sync && at_last;
        end
      endcase
    end
  end

  always_comb begin
    slot_nx = slot;
    if (start) begin
      slot_nx = SW'(1);
    end else if (store) begin
      slot_nx = slot + SW'(1);
    end else if (done) begin
      slot_nx = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
    end else begin
      slot <= slot_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CHANNELS - 1; k++) begin
        shadow[k] <= '0;
      end
    end else begin
      for (int k = 0; k < CHANNELS - 1; k++) begin
        if (start && k == 0) begin
          shadow[k] <= din;
        end else if (store && slot == SW'(k)) begin
          shadow[k] <= din;
        end
      end
    end
  end

  // Last channel bypasses the shadow buffer.
  always_comb begin
    frame = '0;
    for (int k = 0; k < CHANNELS - 1; k++) begin
      frame[k*WIDTH +: WIDTH] = shadow[k];
    end
    frame[(CHANNELS-1)*WIDTH +: WIDTH] = din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      locked     <= 1'b0;
    end else begin
      if (done) begin
        dout <= frame;
      end
      dout_valid <= done;
      frame_err  <= err;
      locked     <= (state_nx == LOCK);
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed scoreboard bench for tdm_demux.
// Drives on negedge, checks #1 after posedge.
module tb_tdm_demux;

  logic        clk;
  logic        rst_n;
  logic [7:0]  din;
  logic        din_valid;
  logic        frame_sync;
  logic [31:0] dout;
  logic        dout_valid;
  logic        locked;
  logic        frame_err;

  int ncmp;
  int nfail;

  logic [31:0] sb [$];
  logic [31:0] exp_dout;

  tdm_demux #(
    .CHANNELS(4),
    .WIDTH(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .din(din),
    .din_valid(din_valid),
    .frame_sync(frame_sync),
    .dout(dout),
    .dout_valid(dout_valid),
    .locked(locked),
    .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag,
                      input logic ev,
                      input logic ee,
                      input logic el);
    if (ev) begin
      if (sb.size() == 0) begin
        chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
        exp_dout = sb.pop_front();
      end
    end
    chk({tag, "_dout"}, dout, exp_dout);
    chk({tag, "_vld"}, 32'(dout_valid), 32'(ev));
    chk({tag, "_err"}, 32'(frame_err), 32'(ee));
    chk({tag, "_lck"}, 32'(locked), 32'(el));
  endtask

  task automatic step(input string tag,
                      input logic [7:0] d,
                      input logic s,
                      input logic ev,
                      input logic ee,
                      input logic el);
    @(negedge clk);
    din        = d;
    din_valid  = 1'b1;
    frame_sync = s;
    @(posedge clk);
    #1;
    outs(tag, ev, ee, el);
  endtask

  // Idle cycles drive junk and a stray sync to prove they are ignored.
  task automatic idle(input string tag,
                      input int n,
                      input logic el);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      din        = 8'($urandom_range(0, 255));
      din_valid  = 1'b0;
      frame_sync = 1'b1;
      @(posedge clk);
      #1;
      outs(tag, 1'b0, 1'b0, el);
    end
  endtask

  initial begin
    ncmp       = 0;
    nfail      = 0;
    exp_dout   = '0;
    rst_n      = 1'b0;
    din        = '0;
    din_valid  = 1'b0;
    frame_sync = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    outs("rst", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle("idle", 3, 1'b0);

    step("hunt_aa", 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
    step("hunt_bb", 8'hBB, 1'b0, 1'b0, 1'b0, 1'b0);
    step("hunt_c1", 8'hC1, 1'b1, 1'b0, 1'b0, 1'b1);
    step("hunt_c2", 8'hC2, 1'b0, 1'b0, 1'b0, 1'b1);
    step("hunt_c3", 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1);
    sb.push_back(32'hC4C3C2C1);
    step("hunt_c4", 8'hC4, 1'b0, 1'b1, 1'b0, 1'b1);

    step("clean_11", 8'h11, 1'b1, 1'b0, 1'b0, 1'b1);
    step("clean_22", 8'h22, 1'b0, 1'b0, 1'b0, 1'b1);
    step("clean_33", 8'h33, 1'b0, 1'b0, 1'b0, 1'b1);
    sb.push_back(32'h44332211);
    step("clean_44", 8'h44, 1'b0, 1'b1, 1'b0, 1'b1);
    step("clean_55", 8'h55, 1'b1, 1'b0, 1'b0, 1'b1);
    step("clean_66", 8'h66, 1'b0, 1'b0, 1'b0, 1'b1);
    step("clean_77", 8'h77, 1'b0, 1'b0, 1'b0, 1'b1);
    sb.push_back(32'h88776655);
    step("clean_88", 8'h88, 1'b0, 1'b1, 1'b0, 1'b1);

    step("gap_11", 8'h11, 1'b1, 1'b0, 1'b0, 1'b1);
    idle("gap_i1", 3, 1'b1);
    step("gap_22", 8'h22, 1'b0, 1'b0, 1'b0, 1'b1);
    idle("gap_i2", 3, 1'b1);
    step("gap_33", 8'h33, 1'b0, 1'b0, 1'b0, 1'b1);
    idle("gap_i3", 3, 1'b1);
    sb.push_back(32'h44332211);
    step("gap_44", 8'h44, 1'b0, 1'b1, 1'b0, 1'b1);
    idle("gap_i4", 2, 1'b1);

    step("early_01", 8'h01, 1'b1, 1'b0, 1'b0, 1'b1);
    step("early_02", 8'h02, 1'b0, 1'b0, 1'b0, 1'b1);
    step("early_10", 8'h10, 1'b1, 1'b0, 1'b1, 1'b1);
    step("early_20", 8'h20, 1'b0, 1'b0, 1'b0, 1'b1);
    step("early_30", 8'h30, 1'b0, 1'b0, 1'b0, 1'b1);
    sb.push_back(32'h40302010);
    step("early_40", 8'h40, 1'b0, 1'b1, 1'b0, 1'b1);

    step("last_11", 8'h11, 1'b1, 1'b0, 1'b0, 1'b1);
    step("last_22", 8'h22, 1'b0, 1'b0, 1'b0, 1'b1);
    step("last_33", 8'h33, 1'b0, 1'b0, 1'b0, 1'b1);
    step("last_50", 8'h50, 1'b1, 1'b0, 1'b1, 1'b1);
    step("last_60", 8'h60, 1'b0, 1'b0, 1'b0, 1'b1);
    step("last_70", 8'h70, 1'b0, 1'b0, 1'b0, 1'b1);
    sb.push_back(32'h80706050);
    step("last_80", 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);

    step("miss_99", 8'h99, 1'b0, 1'b0, 1'b1, 1'b0);
    idle("miss_hold", 2, 1'b0);
    step("miss_a1", 8'hA1, 1'b1, 1'b0, 1'b0, 1'b1);
    step("miss_a2", 8'hA2, 1'b0, 1'b0, 1'b0, 1'b1);

    #2;
    rst_n = 1'b0;
    #1;
    exp_dout = '0;
    outs("midrst", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle("post_rst", 1, 1'b0);
    step("post_a3", 8'hA3, 1'b0, 1'b0, 1'b0, 1'b0);
    step("post_d1", 8'hD1, 1'b1, 1'b0, 1'b0, 1'b1);
    step("post_d2", 8'hD2, 1'b0, 1'b0, 1'b0, 1'b1);
    step("post_d3", 8'hD3, 1'b0, 1'b0, 1'b0, 1'b1);
    sb.push_back(32'hD4D3D2D1);
    step("post_d4", 8'hD4, 1'b0, 1'b1, 1'b0, 1'b1);
    idle("tail", 1, 1'b1);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
